// File: rtl/shift_parity_pkg.sv
// Shared types and default sizing for the shift/parity responder.
package shift_parity_pkg;

    localparam int unsigned M_WIDTH_DEF     = 3;
    localparam int unsigned INPUT_WIDTH_DEF = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/count_mod_m.sv
// Combinational k % M_WIDTH, giving the random_out bit that a job writes.
module count_mod_m #(
    parameter int unsigned M_WIDTH = 3,
    parameter int unsigned BIT_W   = 2
) (
    input  logic [M_WIDTH-1:0] k,
    output logic [BIT_W-1:0]   bit_idx_c
);

    assign bit_idx_c = BIT_W'(32'(k) % 32'(M_WIDTH));

endmodule

// File: rtl/shift_parity_responder.sv
// Responder side of the count/start_shift/done handshake: shifts the latched
// input by k, folds parity over the low window and stores it in random_out.
module shift_parity_responder
    import shift_parity_pkg::*;
#(
    parameter int unsigned M_WIDTH     = M_WIDTH_DEF,
    parameter int unsigned INPUT_WIDTH = INPUT_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INPUT_WIDTH-1:0] in,
    input  logic [M_WIDTH-1:0]     count,
    input  logic                   start_shift,
    output logic                   done_shift,
    output logic                   done_upcount,
    output logic [M_WIDTH-1:0]     random_out,
    output logic                   busy
);

    localparam int unsigned IDX_W = $clog2(M_WIDTH + 1);
    localparam int unsigned BIT_W = (M_WIDTH > 1) ? $clog2(M_WIDTH) : 1;

    state_t                 state;
    state_t                 state_next;
    logic [INPUT_WIDTH-1:0] sreg;
    logic [M_WIDTH-1:0]     k;
    logic [M_WIDTH-1:0]     shift_cnt;
    logic [M_WIDTH-1:0]     last_count;
    logic [IDX_W-1:0]       idx;
    logic                   par;
    logic                   last_start;
    logic                   done_next;
    logic                   busy_next;
    logic [BIT_W-1:0]       bit_idx_c;
    logic [M_WIDTH-1:0]     window_c;
    logic                   accept_c;
    logic                   shift_last_c;
    logic                   count_last_c;

    count_mod_m #(
        .M_WIDTH (M_WIDTH),
        .BIT_W   (BIT_W)
    ) u_count_mod_m (
        .k         (k),
        .bit_idx_c (bit_idx_c)
    );

    // Re-accept only on a start edge or a new count so a held start yields one job per count.
    assign accept_c     = (state == IDLE) && start_shift &&
                          (!last_start || (count != last_count));
    assign window_c     = sreg[M_WIDTH-1:0];
    // The shift that brings shift_cnt up to k is the last SHIFT cycle; k=0 still spends one.
    assign shift_last_c = (k == '0) || (shift_cnt == (k - M_WIDTH'(1)));
    assign count_last_c = (idx == IDX_W'(M_WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_c)     state_next = SHIFT;
            SHIFT:   if (shift_last_c) state_next = COUNT;
            COUNT:   if (count_last_c) state_next = DONE;
            DONE:                      state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    // Flags are registered from the next state so they line up with the state they describe.
    always_comb begin
        done_next = 1'b0;
        busy_next = 1'b0;
        done_next = (state_next == DONE);
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg         <= '0;
            k            <= '0;
            shift_cnt    <= '0;
            idx          <= '0;
            par          <= 1'b0;
            random_out   <= '0;
            done_shift   <= 1'b0;
            done_upcount <= 1'b0;
            busy         <= 1'b0;
            last_start   <= 1'b0;
            last_count   <= '0;
        end else begin
            last_start   <= start_shift;
            last_count   <= count;
            done_shift   <= done_next;
            done_upcount <= done_next;
            busy         <= busy_next;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        sreg      <= in;
                        k         <= count;
                        shift_cnt <= '0;
                        par       <= 1'b0;
                        idx       <= '0;
                    end
                end
                SHIFT: begin
                    if (shift_cnt < k) begin
                        sreg      <= sreg >> 1;
                        shift_cnt <= shift_cnt + M_WIDTH'(1);
                    end
                end
                COUNT: begin
                    par <= par ^ window_c[idx];
                    idx <= idx + IDX_W'(1);
                    if (count_last_c) begin
                        random_out[bit_idx_c] <= par ^ window_c[M_WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_parity_responder.sv
// Scoreboard bench for shift_parity_responder: jobs push expected results,
// a negedge monitor pops and compares them when done pulses.
module tb_shift_parity_responder;

    localparam logic [9:0] IN_VEC = 10'b1011001101;

    typedef struct {
        logic [2:0] ro;
        int         accept_cyc;
        int         lat;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [9:0] in_vec;
    logic [2:0] count;
    logic       start_shift;
    logic       done_shift;
    logic       done_upcount;
    logic [2:0] random_out;
    logic       busy;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [2:0] model_ro;
    logic       prev_done;
    int         cyc;
    int         errors;
    int         checks;

    shift_parity_responder #(
        .M_WIDTH     (3),
        .INPUT_WIDTH (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in           (in_vec),
        .count        (count),
        .start_shift  (start_shift),
        .done_shift   (done_shift),
        .done_upcount (done_upcount),
        .random_out   (random_out),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Done must pair up, last one cycle, and match the oldest outstanding job.
    always @(negedge clk) begin
        if (!rst) begin
            check("done_pair", 32'(done_shift), 32'(done_upcount));
            check("done_width", 32'(prev_done & done_shift), 32'd0);
            if (done_shift) begin
                check("busy_in_done", 32'(busy), 32'd1);
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done_shift), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("random_out", 32'(random_out), 32'(mon_e.ro));
                    check("latency", 32'(cyc - mon_e.accept_cyc), 32'(mon_e.lat));
                end
            end
            prev_done = done_shift;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic run_job(input logic [2:0] k, input int lat);
        logic [9:0] shifted;
        exp_t       e;
        int         n;
        @(negedge clk);
        count       = k;
        start_shift = 1'b1;
        shifted     = IN_VEC >> k;
        model_ro[2'(k % 3'd3)] = ^shifted[2:0];
        e.ro         = model_ro;
        e.accept_cyc = cyc + 1;
        e.lat        = lat;
        sb.push_back(e);
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n = n + 1;
        end
        if (sb.size() != 0) begin
            check("timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        prev_done   = 1'b0;
        model_ro    = 3'b000;
        rst         = 1'b1;
        start_shift = 1'b0;
        count       = 3'd0;
        in_vec      = IN_VEC;

        repeat (2) @(negedge clk);
        check("rst_random_out", 32'(random_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_shift", 32'(done_shift), 32'd0);
        check("rst_done_upcount", 32'(done_upcount), 32'd0);
        rst = 1'b0;

        run_job(3'd3, 6);
        run_job(3'd4, 7);
        run_job(3'd2, 5);
        run_job(3'd0, 4);

        // Start stays high with count unchanged: nothing new may start.
        repeat (8) begin
            @(negedge clk);
            check("no_retrigger", 32'(busy), 32'd0);
        end

        // Abort a k=1 job during its first COUNT cycle.
        @(negedge clk);
        count = 3'd1;
        repeat (2) @(negedge clk);
        check("busy_mid_job", 32'(busy), 32'd1);
        rst         = 1'b1;
        start_shift = 1'b0;
        #1;
        check("abort_random_out", 32'(random_out), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done_shift", 32'(done_shift), 32'd0);
        check("abort_done_upcount", 32'(done_upcount), 32'd0);
        model_ro = 3'b000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("idle_after_abort", 32'(busy), 32'd0);
        end

        run_job(3'd3, 6);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
